timer_unit: RTL and testbench

TIMER_UNIT -- requirements
Module: timer_unit

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_prescaler.sv | 45 ++++
 rtl/timer_unit.sv | 145 ++++++++++++++
 tb/tb_timer_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and constants for the timer unit: FSM state
//                encoding, counter width and the default prescale divisor.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

    // Width of the load, reload, counter and snapshot registers.
    localparam int COUNT_W = 16;

    // Default number of clk cycles per count tick.
    localparam int PRESCALE_DIV_DEFAULT = 1;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Free-running divider producing one tick every PRESCALE_DIV
//                enabled cycles. The counter runs 0..PRESCALE_DIV-1 and the
//                tick is asserted during the cycle it holds the last value.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk     in   system clock
//    rst     in   synchronous active-high reset
//    enable  in   advance the divider this cycle
//    clear   in   force the divider back to 0 (overrides enable)
//    tick    out  combinational tick, valid in the cycle the count wraps
// ============================================================================
module timer_prescaler #(
    parameter int PRESCALE_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    // A divisor of 1 still needs a one-bit register to stay legal.
    localparam int                CNT_W  = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(PRESCALE_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == C_LAST);
    assign tick   = enable && w_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/timer_unit.sv
`default_nettype none
// ============================================================================
//  Module      : timer_unit
//  Description : 16-bit down-counting timer with prescaler, load/capture
//                strobes and a sticky expiry interrupt.
//                Build option TIMER_AUTORELOAD_EN: when defined the counter
//                reloads on expiry and keeps running (periodic interrupt);
//                when undefined the timer stops in EXPIRED (one-shot).
//  Revision    : 1.0  initial release
//
//  Ports
//    clk           in   system clock
//    rst           in   synchronous active-high reset
//    timer_cs      in   chip select, qualifies wr/start/rd
//    timer_wr      in   load strobe (reload and counter <= timer_datain)
//    timer_start   in   level-sensitive run enable
//    timer_rd      in   capture strobe (timer_value <= counter, clears INT)
//    timer_datain  in   16-bit load value
//    timer_value   out  registered counter snapshot
//    timer_INT     out  registered sticky expiry flag
// ============================================================================
module timer_unit
    import timer_pkg::*;
#(
    parameter int PRESCALE_DIV = PRESCALE_DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_cs,
    input  logic               timer_wr,
    input  logic               timer_start,
    input  logic               timer_rd,
    input  logic [COUNT_W-1:0] timer_datain,
    output logic [COUNT_W-1:0] timer_value,
    output logic               timer_INT
);

    timer_state_t       r_state;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_value;
    logic               r_int;

    logic w_wr;
    logic w_run;
    logic w_rd;
    logic w_presc_en;
    logic w_tick;
    logic w_expire;

    assign w_wr  = timer_cs && timer_wr;
    assign w_run = timer_cs && timer_start;
    assign w_rd  = timer_cs && timer_rd;

    // The divider only advances while actually running; a load in the same
    // cycle wins and restarts it from zero instead.
    assign w_presc_en = (r_state == RUN) && w_run && !w_wr;
    assign w_expire   = w_tick && (r_count == '0);

    timer_prescaler #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (w_presc_en),
        .clear  (w_wr),
        .tick   (w_tick)
    );

`ifdef TIMER_AUTORELOAD_EN
    // The reload value is only ever consumed when reloading on expiry, so
    // the register exists only in the periodic build.
    logic [COUNT_W-1:0] r_reload;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reload <= '0;
        end else if (w_wr) begin
            r_reload <= timer_datain;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STOP;
            r_count <= '0;
            r_value <= '0;
            r_int   <= 1'b0;
        end else begin
            // Capture samples the pre-update count regardless of other controls.
            if (w_rd) begin
                r_value <= r_count;
            end

            if (w_wr) begin
                r_count <= timer_datain;
                r_int   <= 1'b0;
                r_state <= STOP;
            end else begin
                // Expiry outranks the clear-on-read of the interrupt.
                if (w_expire) begin
                    r_int <= 1'b1;
                end else if (w_rd) begin
                    r_int <= 1'b0;
                end

                case (r_state)
                    STOP: begin
                        if (w_run) begin
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!w_run) begin
                            r_state <= STOP;
                        end else if (w_tick) begin
                            if (r_count != '0) begin
                                r_count <= r_count - 1'b1;
                            end else begin
`ifdef TIMER_AUTORELOAD_EN
                                r_count <= r_reload;
`else
                                r_state <= EXPIRED;
`endif
                            end
                        end
                    end
                    EXPIRED: begin
                        if (!w_run) begin
                            r_state <= STOP;
                        end
                    end
                    default: begin
                        r_state <= STOP;
                    end
                endcase
            end
        end
    end

    assign timer_value = r_value;
    assign timer_INT   = r_int;

endmodule : timer_unit
`default_nettype wire

// File: tb/tb_timer_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_unit
//  Description : Self-checking bench for timer_unit. Stimulus pushes the
//                expected capture values and interrupt rise cycles into
//                queues; a monitor pops and compares whenever the DUT
//                presents a capture or an interrupt rising edge. A second
//                instance with PRESCALE_DIV=4 covers the prescaler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_unit;

`ifdef TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, wr, start, rd;
    logic [15:0] din;
    logic [15:0] val;
    logic        irq;

    logic        cs4, wr4, start4, rd4;
    logic [15:0] din4;
    logic [15:0] val4;
    logic        int4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int exp_val_q[$];
    int exp_int_q[$];

    always #5 clk = ~clk;

    timer_unit #(.PRESCALE_DIV(1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .timer_cs     (cs),
        .timer_wr     (wr),
        .timer_start  (start),
        .timer_rd     (rd),
        .timer_datain (din),
        .timer_value  (val),
        .timer_INT    (irq)
    );

    timer_unit #(.PRESCALE_DIV(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .timer_cs     (cs4),
        .timer_wr     (wr4),
        .timer_start  (start4),
        .timer_rd     (rd4),
        .timer_datain (din4),
        .timer_value  (val4),
        .timer_INT    (int4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scores every capture and every interrupt rising edge.
    logic mon_rd;
    logic irq_last = 1'b0;
    always begin
        @(posedge clk);
        mon_rd = cs && rd && !rst;
        cyc    = cyc + 1;
        #1;
        if (mon_rd) begin
            if (exp_val_q.size() == 0) begin
                check("rd_unexpected", 32'(val), 32'hDEAD_BEEF);
            end else begin
                check("rd_value", 32'(val), 32'(exp_val_q.pop_front()));
            end
        end
        if (irq && !irq_last) begin
            if (exp_int_q.size() == 0) begin
                check("int_unexpected_rise", 32'(cyc), 32'hDEAD_BEEF);
            end else begin
                check("int_rise_cycle", 32'(cyc), 32'(exp_int_q.pop_front()));
            end
        end
        irq_last = irq;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic load(input logic [15:0] v);
        wr  = 1'b1;
        din = v;
        tick(1);
        wr  = 1'b0;
    endtask

    task automatic capture(input int exp);
        exp_val_q.push_back(exp);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    int c;

    initial begin
        rst = 1'b1;
        cs = 1'b0; wr = 1'b0; start = 1'b0; rd = 1'b0; din = '0;
        cs4 = 1'b0; wr4 = 1'b0; start4 = 1'b0; rd4 = 1'b0; din4 = '0;
        tick(3);
        rst = 1'b0;
        check("reset_value", 32'(val), 32'h0);
        check("reset_int", 32'(irq), 32'h0);
        check("reset_value_div4", 32'(val4), 32'h0);
        check("reset_int_div4", 32'(int4), 32'h0);
        cs = 1'b1;

        // Basic expiry: load 5, INT 6 cycles after start is first sampled.
        load(16'd5);
        start = 1'b1;
        c = cyc;
        exp_int_q.push_back(c + 7);
        tick(6);
        check("int_before_expiry", 32'(irq), 32'h0);
        tick(1);
        check("int_at_expiry", 32'(irq), 32'h1);
        start = 1'b0;
        capture(AR ? 5 : 0);
        check("int_cleared_by_rd", 32'(irq), 32'h0);

        // Pause: 10 decrements from 100, then hold.
        load(16'd100);
        start = 1'b1;
        tick(11);
        start = 1'b0;
        tick(1);
        capture(90);
        tick(3);
        check("value_held_in_pause", 32'(val), 32'd90);
        capture(90);
        check("int_idle_after_pause", 32'(irq), 32'h0);

        // Periodic (autoreload) or one-shot behaviour with load 3.
        load(16'd3);
        start = 1'b1;
        c = cyc;
        if (AR) begin
            for (int k = 0; k < 4; k++) exp_int_q.push_back(c + 5 + 4 * k);
            tick(5);
            for (int k = 0; k < 4; k++) begin
                check("ar_int_set", 32'(irq), 32'h1);
                capture(3);
                check("ar_int_cleared", 32'(irq), 32'h0);
                if (k < 3) tick(3);
            end
        end else begin
            exp_int_q.push_back(c + 5);
            tick(5);
            check("os_int_set", 32'(irq), 32'h1);
            tick(5);
            check("os_int_sticky", 32'(irq), 32'h1);
            capture(0);
            check("os_int_cleared", 32'(irq), 32'h0);
            tick(3);
            check("os_no_restart", 32'(irq), 32'h0);
        end
        start = 1'b0;
        tick(1);

        // RD in the exact expiry cycle: INT must stay set.
        load(16'd2);
        start = 1'b1;
        c = cyc;
        tick(3);
        exp_int_q.push_back(c + 4);
        capture(0);
        check("rd_expiry_collision_int", 32'(irq), 32'h1);
        start = 1'b0;
        capture(AR ? 2 : 0);
        check("int_cleared_after_collision", 32'(irq), 32'h0);

        // WR in the expiry cycle: INT stays clear, count takes the new value.
        load(16'd1);
        start = 1'b1;
        tick(2);
        wr  = 1'b1;
        din = 16'h1234;
        tick(1);
        wr    = 1'b0;
        start = 1'b0;
        check("wr_expiry_collision_int", 32'(irq), 32'h0);
        capture(16'h1234);

        // Load of zero expires on the first tick.
        load(16'd0);
        start = 1'b1;
        c = cyc;
        exp_int_q.push_back(c + 2);
        tick(2);
        check("zero_load_int", 32'(irq), 32'h1);
        start = 1'b0;
        capture(0);
        check("zero_load_int_cleared", 32'(irq), 32'h0);

        // Reset mid-expiry with start held: everything back to zero / STOP.
        load(16'd7);
        start = 1'b1;
        c = cyc;
        tick(4);
        capture(4);
        exp_int_q.push_back(c + 9);
        tick(4);
        check("pre_reset_int", 32'(irq), 32'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_run_reset_value", 32'(val), 32'h0);
        check("mid_run_reset_int", 32'(irq), 32'h0);
        c = cyc;
        exp_int_q.push_back(c + 2);
        tick(2);
        check("post_reset_count_zero", 32'(irq), 32'h1);
        start = 1'b0;
        capture(0);
        check("post_reset_int_cleared", 32'(irq), 32'h0);
        cs = 1'b0;

        // Prescaler of 4: load 2 expires 12 cycles after start.
        cs4  = 1'b1;
        wr4  = 1'b1;
        din4 = 16'd2;
        tick(1);
        wr4    = 1'b0;
        start4 = 1'b1;
        tick(12);
        check("div4_int_before", 32'(int4), 32'h0);
        tick(1);
        check("div4_int_at_12", 32'(int4), 32'h1);
        rd4 = 1'b1;
        tick(1);
        rd4 = 1'b0;
        check("div4_rd_value", 32'(val4), AR ? 32'd2 : 32'd0);
        check("div4_int_cleared", 32'(int4), 32'h0);
        wr4  = 1'b1;
        din4 = 16'd2;
        tick(1);
        wr4 = 1'b0;
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("div4_reset_value", 32'(val4), 32'h0);
        check("div4_reset_int", 32'(int4), 32'h0);
        tick(4);
        check("div4_post_reset_int_before", 32'(int4), 32'h0);
        tick(1);
        check("div4_post_reset_first_tick", 32'(int4), 32'h1);
        start4 = 1'b0;
        tick(3);

        check("leftover_rd_expectations", 32'(exp_val_q.size()), 32'h0);
        check("leftover_int_expectations", 32'(exp_int_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_timer_unit
`default_nettype wire
